// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect unit: FSM encoding and PC constants.
package pc_redirect_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SHADOW = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;
    localparam logic [63:0] INSTR_BYTES      = 64'd4;

endpackage

// File: rtl/pc_redirect_unit_pc_next_mux.sv
// Next-PC selection: hold, sequential PC+4, or redirect target.
module pc_next_mux
    import pc_redirect_unit_pkg::*;
(
    input  state_e      state_i,
    input  logic        take_i,
    input  logic        misalign_i,
    input  logic        stall_i,
    input  logic [63:0] pc_i,
    input  logic [63:0] target_i,
    output logic [63:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        case (state_i)
            ST_RUN: begin
                // A taken branch overrides Stall; a misaligned one freezes PC.
                if (misalign_i)    pc_next_o = pc_i;
                else if (take_i)   pc_next_o = target_i;
                else if (!stall_i) pc_next_o = pc_i + INSTR_BYTES;
            end
            ST_SHADOW: begin
                if (!stall_i) pc_next_o = pc_i + INSTR_BYTES;
            end
            default: pc_next_o = pc_i;
        endcase
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: sequential fetch, stall hold, taken-branch redirect
// with flush, post-redirect shadow window and sticky misalign halt.
//
//   state  | meaning
//   BOOT   | after reset, PC = RESET_VECTOR, not yet fetching
//   RUN    | fetching, branch resolves accepted
//   SHADOW | fetching after a redirect, branch resolves ignored
//   HALT   | misaligned target seen, frozen until reset
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR  = RESET_VECTOR_DEF,
    parameter int unsigned SHADOW_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        EXValid,
    input  logic        Branch,
    input  logic        UncondBranch,
    input  logic        Zero,
    input  logic [63:0] ALUBranch_Out3,
    output logic [63:0] PC,
    output logic        PCValid,
    output logic        Flush,
    output logic        Fault,
    output logic [31:0] TakenCount
);

    localparam int CW = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES + 1) : 1;

    state_e        state_q, state_d;
    logic [63:0]   pc_q, pc_d;
    logic          fault_q, fault_d;
    logic [31:0]   taken_q, taken_d;
    logic [CW-1:0] shadow_q, shadow_d;
    logic          take, misalign;

    assign take     = EXValid & (UncondBranch | (Branch & Zero)) & (state_q == ST_RUN);
    assign misalign = take & (ALUBranch_Out3[1:0] != 2'b00);

    pc_next_mux u_pc_next_mux (
        .state_i    (state_q),
        .take_i     (take),
        .misalign_i (misalign),
        .stall_i    (Stall),
        .pc_i       (pc_q),
        .target_i   (ALUBranch_Out3),
        .pc_next_o  (pc_d)
    );

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        taken_d  = taken_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (misalign) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else if (take) begin
                    taken_d  = taken_q + 32'd1;
                    shadow_d = CW'(SHADOW_CYCLES);
                    state_d  = (SHADOW_CYCLES == 0) ? ST_RUN : ST_SHADOW;
                end
            end
            ST_SHADOW: begin
                // Counts down on stalled edges too; leaves as it hits zero.
                shadow_d = shadow_q - CW'(1);
                if (shadow_q <= CW'(1)) state_d = ST_RUN;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_VECTOR;
            fault_q  <= 1'b0;
            taken_q  <= 32'd0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fault_q  <= fault_d;
            taken_q  <= taken_d;
            shadow_q <= shadow_d;
        end
    end

    assign PC         = pc_q;
    assign PCValid    = (state_q == ST_RUN) || (state_q == ST_SHADOW);
    assign Flush      = take;
    assign Fault      = fault_q;
    assign TakenCount = taken_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit with hand-computed expectations.
module tb_pc_redirect_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        EXValid;
    logic        Branch;
    logic        UncondBranch;
    logic        Zero;
    logic [63:0] ALUBranch_Out3;
    logic [63:0] PC;
    logic        PCValid;
    logic        Flush;
    logic        Fault;
    logic [31:0] TakenCount;

    int n_checks = 0;
    int n_errors = 0;

    pc_redirect_unit #(
        .RESET_VECTOR  (64'h100),
        .SHADOW_CYCLES (2)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .Stall          (Stall),
        .EXValid        (EXValid),
        .Branch         (Branch),
        .UncondBranch   (UncondBranch),
        .Zero           (Zero),
        .ALUBranch_Out3 (ALUBranch_Out3),
        .PC             (PC),
        .PCValid        (PCValid),
        .Flush          (Flush),
        .Fault          (Fault),
        .TakenCount     (TakenCount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_br();
        EXValid = 0; Branch = 0; UncondBranch = 0; Zero = 0;
    endtask

    task automatic drive_br(input logic b, input logic u, input logic z, input logic [63:0] tgt);
        EXValid = 1; Branch = b; UncondBranch = u; Zero = z; ALUBranch_Out3 = tgt;
    endtask

    initial begin
        Reset = 1; Stall = 0; ALUBranch_Out3 = '0;
        clear_br();
        tick(); tick();
        chk("rst_pc", PC, 64'h100);
        chk("rst_valid", {63'd0, PCValid}, 64'd0);
        chk("rst_fault", {63'd0, Fault}, 64'd0);
        chk("rst_taken", {32'd0, TakenCount}, 64'd0);
        Reset = 0;

        // Reset release
        chk("boot_pc", PC, 64'h100);
        chk("boot_valid", {63'd0, PCValid}, 64'd0);
        tick();
        chk("run_pc0", PC, 64'h100);
        chk("run_valid", {63'd0, PCValid}, 64'd1);
        tick();
        chk("run_pc1", PC, 64'h104);
        for (int i = 0; i < 7; i++) tick();
        chk("seq_pc", PC, 64'h120);

        // Taken CBZ, inputs held through the two shadow cycles
        drive_br(1, 0, 1, 64'h200);
        #1 chk("cbz_flush", {63'd0, Flush}, 64'd1);
        tick();
        chk("cbz_pc", PC, 64'h200);
        chk("cbz_taken", {32'd0, TakenCount}, 64'd1);
        chk("sh1_flush", {63'd0, Flush}, 64'd0);
        chk("sh1_valid", {63'd0, PCValid}, 64'd1);
        tick();
        chk("sh2_pc", PC, 64'h204);
        chk("sh2_flush", {63'd0, Flush}, 64'd0);
        tick();
        clear_br();
        chk("post_sh_pc", PC, 64'h208);
        chk("post_sh_taken", {32'd0, TakenCount}, 64'd1);

        // Untaken branch
        drive_br(1, 0, 0, 64'h600);
        #1 chk("untaken_flush", {63'd0, Flush}, 64'd0);
        tick();
        clear_br();
        chk("untaken_pc", PC, 64'h20C);

        // Stall holds PC
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", PC, 64'h20C);
        end

        // Taken branch overrides Stall
        drive_br(0, 1, 0, 64'h300);
        #1 chk("stall_br_flush", {63'd0, Flush}, 64'd1);
        tick();
        clear_br();
        chk("stall_br_pc", PC, 64'h300);
        chk("stall_br_taken", {32'd0, TakenCount}, 64'd2);

        // Shadow counter runs down on stalled edges
        tick();
        chk("sh_stall_pc", PC, 64'h300);
        tick();
        chk("sh_stall_pc2", PC, 64'h300);
        Stall = 0;
        drive_br(0, 1, 0, 64'h400);
        #1 chk("sh_exit_flush", {63'd0, Flush}, 64'd1);
        tick();
        clear_br();
        chk("sh_exit_pc", PC, 64'h400);
        chk("sh_exit_taken", {32'd0, TakenCount}, 64'd3);
        tick(); tick();
        chk("pre_mis_pc", PC, 64'h408);

        // Misaligned target
        drive_br(0, 1, 0, 64'h202);
        #1 chk("mis_flush", {63'd0, Flush}, 64'd1);
        tick();
        chk("halt_fault", {63'd0, Fault}, 64'd1);
        chk("halt_valid", {63'd0, PCValid}, 64'd0);
        chk("halt_flush", {63'd0, Flush}, 64'd0);
        chk("halt_taken", {32'd0, TakenCount}, 64'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt_pc", PC, 64'h408);
            chk("halt_fault_k", {63'd0, Fault}, 64'd1);
        end
        clear_br();
        Reset = 1;
        #1;
        chk("halt_rst_pc", PC, 64'h100);
        chk("halt_rst_fault", {63'd0, Fault}, 64'd0);
        chk("halt_rst_taken", {32'd0, TakenCount}, 64'd0);
        #2 Reset = 0;
        tick();
        chk("rerun_valid", {63'd0, PCValid}, 64'd1);

        // PC wraps through zero
        drive_br(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        clear_br();
        chk("wrap_pc0", PC, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        chk("wrap_pc1", PC, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_pc2", PC, 64'h0);
        chk("wrap_fault", {63'd0, Fault}, 64'd0);
        chk("wrap_taken", {32'd0, TakenCount}, 64'd1);

        // TakenCount wraps
        force dut.taken_q = 32'hFFFF_FFFF;
        #1 release dut.taken_q;
        drive_br(0, 1, 0, 64'h500);
        tick();
        clear_br();
        chk("tc_wrap", {32'd0, TakenCount}, 64'd0);
        chk("tc_wrap_pc", PC, 64'h500);

        // Reset mid-SHADOW between edges
        #3 Reset = 1;
        #1;
        chk("mid_rst_pc", PC, 64'h100);
        chk("mid_rst_valid", {63'd0, PCValid}, 64'd0);
        chk("mid_rst_flush", {63'd0, Flush}, 64'd0);
        #1 Reset = 0;
        tick();
        chk("mid_boot_valid", {63'd0, PCValid}, 64'd1);
        chk("mid_boot_pc", PC, 64'h100);
        drive_br(0, 1, 0, 64'h700);
        #1 chk("mid_run_flush", {63'd0, Flush}, 64'd1);
        tick();
        clear_br();
        chk("mid_run_pc", PC, 64'h700);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pc_redirect_unit.md
# pc_redirect_unit

Owns the program counter for the pipelined core. It advances PC by 4 each cycle and stalls on hazard. When the EX-stage branch target adder reports a resolved taken branch, it redirects PC to that target and flushes the two wrong-path instructions. It sits between the EX-stage branch adder (consumer of its target) and the instruction-fetch memory / IF/ID register (consumers of PC and Flush).

## Interface
- RESET_VECTOR, 64'h0, PC value loaded on reset
- SHADOW_CYCLES, 2, cycles during which branch resolves are ignored after a redirect
- CLK  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Stall  input  1  load-use hazard hold; PC keeps its value
- EXValid  input  1  instruction in EX is valid (not a bubble)
- Branch  input  1  conditional branch (CBZ) in EX
- UncondBranch  input  1  unconditional branch (B) in EX
- Zero  input  1  ALU zero flag for the EX instruction
- ALUBranch_Out3  input  64  branch target from the EX branch adder (PC + SignExt<<2)
- PC  output  64  current fetch address
- PCValid  output  1  fetch address is meaningful this cycle
- Flush  output  1  kill IF/ID and ID/EX contents at the next edge
- Fault  output  1  misaligned branch target seen; sticky until reset
- TakenCount  output  32  number of redirects taken since reset, wraps

## Operation
- take = EXValid & (UncondBranch | (Branch & Zero)) & (state == RUN).
- misalign = take & (ALUBranch_Out3[1:0] != 2'b00).
- States: BOOT, RUN, SHADOW, HALT.
- BOOT: entered on reset. PC = RESET_VECTOR, PCValid = 0. Goes to RUN unconditionally next edge; PC does not advance on that edge.
- RUN, in priority order:
  - misalign: go to HALT, Fault <= 1, PC held, Flush = 1.
  - take: PC <= ALUBranch_Out3, Flush = 1, TakenCount += 1, shadow counter <= SHADOW_CYCLES, go to SHADOW. Stall is ignored in this cycle.
  - Stall: PC held.
  - otherwise: PC <= PC + 4.
- SHADOW:
  - PC advances by 4 (or holds on Stall).
  - Branch inputs are ignored and Flush = 0.
  - The counter decrements each edge, including stalled edges. Return to RUN when it reaches 0 at the edge.
  - SHADOW_CYCLES = 0 means a direct return to RUN at the redirect edge; the SHADOW state is skipped.
- HALT: PC frozen, PCValid = 0, Flush = 0, Fault = 1. Left only by Reset.
- Arithmetic: PC + 4 is 64-bit modulo; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no fault. TakenCount wraps from 2^32-1 to 0.
- Reset asserted mid-operation (any state, any cycle) immediately forces BOOT values. Any pending redirect is discarded.

## Timing
- Reset values: PC = RESET_VECTOR, PCValid = 0, Flush = 0, Fault = 0, TakenCount = 0, state = BOOT.
- Flush is combinational from take/misalign and the current state. It is asserted in the same cycle EX resolves, so the pipeline registers squash at the same edge PC redirects.
- Redirect latency: a taken branch in EX in cycle N gives PC = target in cycle N+1.
- Fault and HALT take effect at the edge after misalign.
- PCValid = 1 in RUN and SHADOW, 0 in BOOT and HALT.
- All other outputs are registered.

## Structure
- Shared package: the state encoding (BOOT = 2'd0, RUN = 2'd1, SHADOW = 2'd2, HALT = 2'd3), RESET_VECTOR default, and the instruction-size constant 64'd4.
- One sub-module, pc_next_mux: combinational selection of the next PC from {hold, PC+4, target} given the state, take and Stall.
- The FSM, counters and registers stay in pc_redirect_unit.

## Test plan
- Reset release with RESET_VECTOR = 64'h100:
  - cycle 0: PC = 0x100, PCValid = 0
  - cycle 1: PC = 0x100, PCValid = 1
  - cycle 2: PC = 0x104
- Taken CBZ: in RUN at PC = 0x120, drive EXValid = 1, Branch = 1, Zero = 1, target = 0x200.
  - Flush = 1 that cycle; next cycle PC = 0x200 and TakenCount = 1.
  - Branch inputs held high for 2 more cycles produce no further Flush.
- Untaken branch and stall interaction:
  - Branch = 1, Zero = 0 gives PC + 4 with Flush = 0.
  - Stall = 1 for 3 cycles holds PC.
  - Stall = 1 together with UncondBranch to 0x300 redirects to 0x300.
- Misaligned target 0x202 on UncondBranch:
  - Flush = 1 that cycle.
  - Then Fault = 1, PCValid = 0, PC frozen for 10 cycles.
  - Reset clears it back to RESET_VECTOR.
- Wrap cases:
  - PC = 0xFFFF_FFFF_FFFF_FFFC advances to 0.
  - TakenCount preloaded (via 2^32-1 redirects, or force) wraps to 0.
- Reset pulse asserted mid-SHADOW, between clock edges:
  - Outputs go to reset values immediately.
  - The shadow counter is cleared, and BOOT is re-entered.
